// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master: the FSM state type, divider, word and
// back-porch sizes, slave index constants, and the slave-select decoder.
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        XFER       = 2'd1,
        BACK_PORCH = 2'd2
    } state_t;

    localparam int DIV_W    = 5;                  // SCLK divider width (period 32 clk)
    localparam int WORD_LEN = 16;                 // bits per transaction
    localparam int BP_LEN   = 16;                 // back-porch length in clk
    localparam int CNT_W    = $clog2(WORD_LEN);   // bit counter width
    localparam int NUM_SS   = 5;                  // number of slave-select lines

    localparam logic [2:0] AFE_CH1 = 3'd0;
    localparam logic [2:0] AFE_CH2 = 3'd1;
    localparam logic [2:0] AFE_CH3 = 3'd2;
    localparam logic [2:0] TRIG    = 3'd3;
    localparam logic [2:0] EEPROM  = 3'd4;

    // Active-low one-hot select; indices with no attached slave select nothing.
    function automatic logic [NUM_SS-1:0] ss_decode(input logic [2:0] idx);
        logic [NUM_SS-1:0] one_hot;
        one_hot = {{(NUM_SS-1){1'b0}}, 1'b1} << idx;
        return (idx <= EEPROM) ? ~one_hot : {NUM_SS{1'b1}};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen
// Free-running divider for the SPI master. SCLK is the divider MSB while a word
// is shifting; the sample strobe fires the cycle before SCLK rises and the shift
// strobe fires on the cycle SCLK falls. The same divider times the back porch.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : clear the divider (transaction start)
//   run         : advance the divider (any non-idle state)
//   xfer        : word is shifting; gates SCLK and the strobes
//   sclk        : serial clock, idles low
//   smpl        : sample MISO this cycle
//   shft        : shift the word this cycle
//   porch_done  : divider has reached the end of the back porch
// -----------------------------------------------------------------------------
module spi_sclk_gen
    import spi_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    input  logic xfer,
    output logic sclk,
    output logic smpl,
    output logic shft,
    output logic porch_done
);

    localparam logic [DIV_W-1:0] SMPL_PT   = DIV_W'((2 ** (DIV_W - 1)) - 1);
    localparam logic [DIV_W-1:0] SHFT_PT   = '1;
    localparam logic [DIV_W-1:0] PORCH_END = DIV_W'(BP_LEN);

    logic [DIV_W-1:0] div;

    // NOTE: clocked state uses non-blocking assignments so every flop sees the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (clr) begin
            div <= '0;
        end else if (run) begin
            div <= div + 1'b1;
        end
    end

    assign sclk       = xfer & div[DIV_W-1];
    assign smpl       = xfer && (div == SMPL_PT);
    assign shft       = xfer && (div == SHFT_PT);
    // The divider wraps to zero on the final shift, so it counts the porch
    // from the first cycle after SCLK's last falling edge.
    assign porch_done = (div == PORCH_END);

endmodule

// File: rtl/spi_mstr.sv
// -----------------------------------------------------------------------------
// spi_mstr
// Mode-0 SPI master: shifts a 16-bit word out MSB first on MOSI while shifting
// the slave's reply in from MISO, with front and back porches around the word.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   wrt_SPI     : one-cycle start strobe (ignored while busy)
//   ss          : slave index, valid only with wrt_SPI
//   SPI_data    : word to send, valid only with wrt_SPI
//   SPI_done    : high once a transaction has finished and the block is idle
//   EEP_data    : low byte of the last received word
//   SCLK, MOSI  : serial clock and data out
//   MISO        : serial data in
//   SS_n        : active-low one-hot slave selects
// -----------------------------------------------------------------------------
module spi_mstr
    import spi_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wrt_SPI,
    input  logic [2:0]          ss,
    input  logic [WORD_LEN-1:0] SPI_data,
    output logic                SPI_done,
    output logic [7:0]          EEP_data,
    output logic                SCLK,
    output logic                MOSI,
    input  logic                MISO,
    output logic [NUM_SS-1:0]   SS_n
);

    state_t              state, nxt_state;
    logic                ld, set_done;
    logic                busy, xfer;
    logic                smpl, shft, porch_done;
    logic [WORD_LEN-1:0] shift_reg;
    logic [2:0]          ss_reg;
    logic [CNT_W-1:0]    bit_cnt;
    logic                miso_ff;
    logic                done;

    assign busy = (state != IDLE);
    assign xfer = (state == XFER);

    spi_sclk_gen u_sclk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (ld),
        .run        (busy),
        .xfer       (xfer),
        .sclk       (SCLK),
        .smpl       (smpl),
        .shft       (shft),
        .porch_done (porch_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        nxt_state = state;
        ld        = 1'b0;
        set_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (wrt_SPI) begin
                    ld        = 1'b1;
                    nxt_state = XFER;
                end
            end
            XFER: begin
                if (shft && (bit_cnt == CNT_W'(WORD_LEN - 1))) begin
                    nxt_state = BACK_PORCH;
                end
            end
            BACK_PORCH: begin
                if (porch_done) begin
                    set_done  = 1'b1;
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            ss_reg    <= '0;
            bit_cnt   <= '0;
            miso_ff   <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (ld) begin
                shift_reg <= SPI_data;
                ss_reg    <= ss;
                bit_cnt   <= '0;
                done      <= 1'b0;
            end else begin
                if (shft) begin
                    shift_reg <= {shift_reg[WORD_LEN-2:0], miso_ff};
                    bit_cnt   <= bit_cnt + 1'b1;
                end
                if (set_done) begin
                    done <= 1'b1;
                end
            end
            if (smpl) begin
                miso_ff <= MISO;
            end
        end
    end

    // Selects decode from the captured index; the ss input is only valid in
    // the strobe cycle.
    assign SS_n     = busy ? ss_decode(ss_reg) : {NUM_SS{1'b1}};
    assign MOSI     = xfer & shift_reg[WORD_LEN-1];
    assign EEP_data = shift_reg[7:0];
    assign SPI_done = done;

endmodule
